// File: rtl/npc_stage_pkg.sv
// Shared types for the NPC multi-cycle core: stage codes, decoder class
// one-hots and the priority helpers that resolve a malformed class word.
package npc_stage_pkg;

    localparam int STAGE_W = 3;

    // Stage codes are also reported to the simulation environment.
    typedef enum logic [STAGE_W-1:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } stage_t;

    // Decoder one-hots, MSB first.
    typedef struct packed {
        logic ebreak;
        logic ecall;
        logic jal;
        logic jalr;
        logic load;
        logic store;
        logic rd_we;
    } inst_class_t;

    // Control-transfer events pulsed in EX (at most one bit set).
    typedef struct packed {
        logic ecall;
        logic jal;
        logic jalr;
    } ex_event_t;

    // Per-instruction state carried from ID to MEM/WB.
    typedef struct packed {
        logic load;
        logic store_only;
        logic rd_we;
    } retire_ctl_t;

    // ecall beats jal beats jalr when the decoder raises several bits.
    function automatic ex_event_t resolve_ex(input inst_class_t cls);
        ex_event_t ev;
        ev.ecall = cls.ecall;
        ev.jal   = cls.jal && !cls.ecall;
        ev.jalr  = cls.jalr && !cls.ecall && !cls.jal;
        return ev;
    endfunction

    // A load with a stray store bit is still treated as a load.
    function automatic retire_ctl_t resolve_retire(input inst_class_t cls);
        retire_ctl_t rc;
        rc.load       = cls.load;
        rc.store_only = cls.store && !cls.load;
        rc.rd_we      = cls.rd_we;
        return rc;
    endfunction

endpackage

// File: rtl/wait_timeout_counter.sv
// Counts consecutive handshake cycles without ready. expire fires in the
// waiting cycle whose miss would bring the count to LIMIT-1, so a ready
// arriving in that same cycle still completes the access.
module wait_timeout_counter #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    // One spare bit keeps LIMIT-2 representable for every LIMIT >= 2.
    localparam int CW = $clog2(LIMIT) + 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(LIMIT - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart outside a handshake, advance on each missed ready.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = tick && !clear && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage controller of the NPC core. Steps each instruction
// through IF/ID/EX/[MEM]/WB, runs the imem/dmem req/ready handshakes and
// emits registered strobes and single-cycle event pulses. Every output is
// a flop whose next value is derived from the next stage.
module stage_sequencer
    import npc_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  inst_class_t        dec_class,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               ir_we,
    output logic               rf_we,
    output logic               pc_we,
    output logic [STAGE_W-1:0] stage,
    output logic               inst_jal,
    output logic               inst_jalr,
    output logic               mem_read_en,
    output logic               mem_write_en,
    output logic               ecall_en,
    output logic               halt,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instret_cnt
);

    stage_t      stage_q, stage_d;
    retire_ctl_t ret_q, ret_d;

    logic imem_req_q, imem_req_d;
    logic dmem_req_q, dmem_req_d;
    logic dmem_we_q, dmem_we_d;
    logic ir_we_q, ir_we_d;
    logic rf_we_q, rf_we_d;
    logic pc_we_q, pc_we_d;
    logic jal_q, jal_d;
    logic jalr_q, jalr_d;
    logic mem_rd_q, mem_rd_d;
    logic mem_wr_q, mem_wr_d;
    logic ecall_q, ecall_d;
    logic halt_q, halt_d;
    logic tmo_q, tmo_d;

    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    ex_event_t ex_evt;

    logic fetch_wait;
    logic data_wait;
    logic fetch_done;
    logic data_done;
    logic wait_clear;
    logic wait_tick;
    logic wait_expire;

    assign ex_evt = resolve_ex(dec_class);

    // A handshake is live only while its request is actually on the bus;
    // ready seen without a request is ignored.
    assign fetch_wait = (stage_q == ST_IF) && imem_req_q;
    assign data_wait  = (stage_q == ST_MEM) && dmem_req_q;
    assign fetch_done = fetch_wait && imem_ready;
    assign data_done  = data_wait && dmem_ready;
    assign wait_clear = !(fetch_wait || data_wait);
    assign wait_tick  = (fetch_wait && !imem_ready) || (data_wait && !dmem_ready);

    wait_timeout_counter #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wait_clear),
        .tick   (wait_tick),
        .expire (wait_expire)
    );

    // State register: current stage plus the class latched in ID.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= ST_IF;
            ret_q   <= '0;
        end else begin
            stage_q <= stage_d;
            ret_q   <= ret_d;
        end
    end

    // Next-stage selection; a completed handshake always beats its timeout.
    always_comb begin
        stage_d = stage_q;
        ret_d   = ret_q;
        case (stage_q)
            ST_IF: begin
                if (fetch_done) begin
                    stage_d = ST_ID;
                end else if (wait_expire) begin
                    stage_d = ST_HALT;
                end
            end
            ST_ID: begin
                ret_d   = resolve_retire(dec_class);
                stage_d = dec_class.ebreak ? ST_HALT : ST_EX;
            end
            ST_EX: begin
                stage_d = (ret_q.load || ret_q.store_only) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (data_done) begin
                    stage_d = ST_WB;
                end else if (wait_expire) begin
                    stage_d = ST_HALT;
                end
            end
            ST_WB: begin
                stage_d = ST_IF;
            end
            ST_HALT: begin
                stage_d = ST_HALT;
            end
            default: begin
                stage_d = ST_IF;
            end
        endcase
    end

    // Next values of the registered outputs, keyed on the stage being entered.
    always_comb begin
        imem_req_d = 1'b0;
        dmem_req_d = 1'b0;
        dmem_we_d  = 1'b0;
        ir_we_d    = 1'b0;
        rf_we_d    = 1'b0;
        pc_we_d    = 1'b0;
        jal_d      = 1'b0;
        jalr_d     = 1'b0;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        ecall_d    = 1'b0;
        halt_d     = 1'b0;
        tmo_d      = tmo_q;
        cycle_d    = cycle_q;
        instret_d  = instret_q;

        if (stage_q != ST_HALT) begin
            cycle_d = cycle_q + CNT_W'(1);
        end
        if (stage_q == ST_WB) begin
            instret_d = instret_q + CNT_W'(1);
        end

        case (stage_d)
            ST_IF: begin
                // Once issued, the fetch request is held regardless of run.
                imem_req_d = fetch_wait || run;
            end
            ST_ID: begin
                ir_we_d = 1'b1;
            end
            ST_EX: begin
                jal_d   = ex_evt.jal;
                jalr_d  = ex_evt.jalr;
                ecall_d = ex_evt.ecall;
            end
            ST_MEM: begin
                dmem_req_d = 1'b1;
                dmem_we_d  = ret_q.store_only;
                if (stage_q == ST_EX) begin
                    mem_rd_d = ret_q.load;
                    mem_wr_d = ret_q.store_only;
                end
            end
            ST_WB: begin
                pc_we_d = 1'b1;
                rf_we_d = ret_q.rd_we;
            end
            ST_HALT: begin
                halt_d = 1'b1;
                tmo_d  = tmo_q || wait_expire;
            end
            default: begin
                halt_d = 1'b0;
            end
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            ir_we_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            pc_we_q    <= 1'b0;
            jal_q      <= 1'b0;
            jalr_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            ecall_q    <= 1'b0;
            halt_q     <= 1'b0;
            tmo_q      <= 1'b0;
            cycle_q    <= '0;
            instret_q  <= '0;
        end else begin
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            ir_we_q    <= ir_we_d;
            rf_we_q    <= rf_we_d;
            pc_we_q    <= pc_we_d;
            jal_q      <= jal_d;
            jalr_q     <= jalr_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            ecall_q    <= ecall_d;
            halt_q     <= halt_d;
            tmo_q      <= tmo_d;
            cycle_q    <= cycle_d;
            instret_q  <= instret_d;
        end
    end

    assign stage        = stage_q;
    assign imem_req     = imem_req_q;
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign ir_we        = ir_we_q;
    assign rf_we        = rf_we_q;
    assign pc_we        = pc_we_q;
    assign inst_jal     = jal_q;
    assign inst_jalr    = jalr_q;
    assign mem_read_en  = mem_rd_q;
    assign mem_write_en = mem_wr_q;
    assign ecall_en     = ecall_q;
    assign halt         = halt_q;
    assign timeout_err  = tmo_q;
    assign cycle_cnt    = cycle_q;
    assign instret_cnt  = instret_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios followed by random
// instruction streams, every cycle compared against a per-instruction
// reference built from the stage rules (lengths, pulses, counters).
module tb_stage_sequencer;
    import npc_stage_pkg::*;

    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic             imem_ready;
    logic             dmem_ready;
    inst_class_t      dec_class;
    logic             imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we;
    logic [2:0]       stage;
    logic             inst_jal, inst_jalr, mem_read_en, mem_write_en, ecall_en;
    logic             halt, timeout_err;
    logic [63:0]      cycle_cnt, instret_cnt;

    typedef struct packed {
        logic [2:0] stage;
        logic imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we;
        logic jal, jalr, mrd, mwr, ecall, halt, tmo;
    } out_t;

    out_t obs;
    int   n_checks = 0;
    int   n_pass   = 0;
    longint unsigned m_cycle   = 0;
    longint unsigned m_instret = 0;
    logic prev_run = 1'b0;
    int   halt_len = 3;

    stage_sequencer #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .dec_class    (dec_class),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_we        (ir_we),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .stage        (stage),
        .inst_jal     (inst_jal),
        .inst_jalr    (inst_jalr),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .ecall_en     (ecall_en),
        .halt         (halt),
        .timeout_err  (timeout_err),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        obs.stage    = stage;
        obs.imem_req = imem_req;
        obs.dmem_req = dmem_req;
        obs.dmem_we  = dmem_we;
        obs.ir_we    = ir_we;
        obs.rf_we    = rf_we;
        obs.pc_we    = pc_we;
        obs.jal      = inst_jal;
        obs.jalr     = inst_jalr;
        obs.mrd      = mem_read_en;
        obs.mwr      = mem_write_en;
        obs.ecall    = ecall_en;
        obs.halt     = halt;
        obs.tmo      = timeout_err;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] x);
        n_checks++;
        assert (o === x) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, o, x);
    endtask

    function automatic inst_class_t junk();
        return inst_class_t'(7'($urandom));
    endfunction

    function automatic logic coin();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs, compare outputs and counters mid-cycle.
    task automatic cyc(input logic r, input logic ir, input logic dr,
                       input inst_class_t dc, input out_t e, input string tag);
        run        = r;
        imem_ready = ir;
        dmem_ready = dr;
        dec_class  = dc;
        @(negedge clk);
        check(tag, {48'd0, obs}, {48'd0, e});
        check({tag, "_cycle_cnt"}, cycle_cnt, m_cycle);
        check({tag, "_instret"}, instret_cnt, m_instret);
        if (e.stage != 3'd5) m_cycle++;
        if (e.stage == 3'd4) m_instret++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        run        = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        dec_class  = junk();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_cycle   = 0;
        m_instret = 0;
        prev_run  = 1'b0;
    endtask

    task automatic halt_run(input int n, input logic tmo);
        out_t e;
        for (int i = 0; i < n; i++) begin
            e       = '0;
            e.stage = ST_HALT;
            e.halt  = 1'b1;
            e.tmo   = tmo;
            cyc(coin(), coin(), coin(), junk(), e, "halt");
        end
    endtask

    // One instruction. res: 0 retired, 1 halted, 2 stopped in MEM for a reset.
    task automatic do_instr(input inst_class_t c, input int li, input int ld,
                            input int gap, input int abort_mem, output int res);
        out_t e;
        logic req, rdy, r;
        int   k, g;
        logic is_mem;
        res = 0;
        req = prev_run;
        k   = 0;
        g   = gap;
        // IF: request follows run one cycle later and is held until ready
        for (int guard = 0; guard < 200; guard++) begin
            e          = '0;
            e.stage    = ST_IF;
            e.imem_req = req;
            rdy        = req && (k == li - 1);
            if (req) r = coin();
            else if (g > 0) begin r = 1'b0; g--; end
            else r = 1'b1;
            cyc(r, rdy, coin(), junk(), e, "if");
            if (rdy) break;
            if (req && k == TO - 2) begin
                halt_run(halt_len, 1'b1);
                res = 1;
                return;
            end
            if (req) k++;
            req = req || r;
        end
        // ID
        e       = '0;
        e.stage = ST_ID;
        e.ir_we = 1'b1;
        cyc(coin(), coin(), coin(), c, e, "id");
        if (c.ebreak) begin
            halt_run(halt_len, 1'b0);
            res = 1;
            return;
        end
        // EX
        e       = '0;
        e.stage = ST_EX;
        e.ecall = c.ecall;
        e.jal   = c.jal && !c.ecall;
        e.jalr  = c.jalr && !c.ecall && !c.jal;
        cyc(coin(), coin(), coin(), junk(), e, "ex");
        // MEM
        is_mem = c.load || c.store;
        if (is_mem) begin
            for (int j = 0; j < 200; j++) begin
                e          = '0;
                e.stage    = ST_MEM;
                e.dmem_req = 1'b1;
                e.dmem_we  = c.store && !c.load;
                e.mrd      = (j == 0) && c.load;
                e.mwr      = (j == 0) && c.store && !c.load;
                rdy        = (j == ld - 1);
                if (j == abort_mem) begin
                    cyc(coin(), coin(), 1'b0, junk(), e, "mem");
                    res = 2;
                    return;
                end
                cyc(coin(), coin(), rdy, junk(), e, "mem");
                if (rdy) break;
                if (j == TO - 2) begin
                    halt_run(halt_len, 1'b1);
                    res = 1;
                    return;
                end
            end
        end
        // WB
        e       = '0;
        e.stage = ST_WB;
        e.pc_we = 1'b1;
        e.rf_we = c.rd_we;
        r       = coin();
        cyc(r, coin(), coin(), junk(), e, "wb");
        prev_run = r;
    endtask

    initial begin
        inst_class_t c;
        int res, kind, li, ld;

        rst_n      = 1'b0;
        run        = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        dec_class  = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // addi, jal, jalr, load (ready on 4th MEM cycle), store, ecall
        do_instr(inst_class_t'(7'b0000001), 1, 1, 0, -1, res);
        do_instr(inst_class_t'(7'b0010001), 1, 1, 0, -1, res);
        do_instr(inst_class_t'(7'b0001001), 2, 1, 1, -1, res);
        do_instr(inst_class_t'(7'b0000101), 1, 4, 0, -1, res);
        do_instr(inst_class_t'(7'b0000010), 1, 1, 0, -1, res);
        do_instr(inst_class_t'(7'b0100000), 1, 1, 0, -1, res);
        // malformed class words resolved by priority
        do_instr(inst_class_t'(7'b0111001), 1, 1, 0, -1, res);
        do_instr(inst_class_t'(7'b0011000), 1, 1, 0, -1, res);
        do_instr(inst_class_t'(7'b0000111), 1, 2, 0, -1, res);
        // ready in the last allowed cycle: no timeout
        do_instr(inst_class_t'(7'b0000101), TO - 1, TO - 1, 0, -1, res);
        check("no_timeout_halt", {63'd0, halt}, 64'd0);

        // reset while a load waits in MEM
        do_instr(inst_class_t'(7'b0000101), 1, 9, 0, 1, res);
        check("abort_in_mem", res, 2);
        do_reset();
        do_instr(inst_class_t'(7'b0000001), 1, 1, 0, -1, res);

        // fetch timeout
        do_instr(inst_class_t'(7'b0000001), 100, 1, 0, -1, res);
        check("if_timeout_res", res, 1);
        check("if_timeout_err", {63'd0, timeout_err}, 64'd1);
        do_reset();
        // data timeout
        do_instr(inst_class_t'(7'b0000010), 1, 100, 0, -1, res);
        check("mem_timeout_res", res, 1);
        do_reset();
        // ebreak parks in HALT for 100 cycles
        halt_len = 100;
        do_instr(inst_class_t'(7'b1000001), 1, 1, 0, -1, res);
        check("ebreak_res", res, 1);
        halt_len = 3;
        do_reset();

        // random instruction stream
        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 15);
            case (kind)
                0, 1, 2: c = inst_class_t'(7'b0000001);
                3:       c = inst_class_t'(7'b0010001);
                4:       c = inst_class_t'(7'b0001001);
                5, 6:    c = inst_class_t'(7'b0000101);
                7, 8:    c = inst_class_t'(7'b0000010);
                9:       c = inst_class_t'(7'b0100000);
                10, 11:  c = inst_class_t'(7'($urandom) & 7'h3f);
                12:      c = inst_class_t'(7'b0000000);
                13:      c = junk();
                default: c = inst_class_t'(7'b0000001);
            endcase
            li = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(1, 4);
            ld = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(1, 5);
            do_instr(c, li, ld, $urandom_range(0, 2), -1, res);
            if (res != 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
